// File: rtl/fpu_stack_tag_ctrl.sv
// fpu_stack_tag_ctrl: FPU tag-register / stack-top sequencer.
// Each accepted op runs IDLE -> CHECK -> COMMIT. CHECK samples tag_in and
// precomputes the new tag word, TOP and fault. COMMIT raises done and the
// write strobe.
// Optional feature macro: FPU_TAG_CLASSIFY_EN. It adds op_value, an 80-bit
// extended real. PUSH and WRITE_ST then take their tag from a classification
// of op_value instead of from op_tag.
module fpu_stack_tag_ctrl #(
    parameter logic [2:0] INIT_TOP = 3'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [2:0]  op_code,
    input  logic [2:0]  op_index,
    input  logic [1:0]  op_tag,
`ifdef FPU_TAG_CLASSIFY_EN
    input  logic [79:0] op_value,
`endif
    input  logic [15:0] tag_in,
    output logic [15:0] tag_wdata,
    output logic        tag_we,
    output logic [2:0]  top,
    output logic        done,
    output logic        stack_fault,
    output logic        c1
);

    localparam logic [2:0] OpPush    = 3'b000;
    localparam logic [2:0] OpPop     = 3'b001;
    localparam logic [2:0] OpWriteSt = 3'b010;
    localparam logic [2:0] OpFree    = 3'b011;
    localparam logic [2:0] OpInit    = 3'b100;
    localparam logic [2:0] OpIncstp  = 3'b101;
    localparam logic [2:0] OpDecstp  = 3'b110;
    localparam logic [2:0] OpCheckSt = 3'b111;

    localparam logic [1:0] TagEmpty = 2'b11;

    typedef enum logic [1:0] {StIdle, StCheck, StCommit} state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [2:0]  r_code;
    logic [2:0]  r_index;
    logic [1:0]  r_tag;
    logic [2:0]  r_top;
    logic [2:0]  r_new_top;
    logic [15:0] r_tag_wdata;
    logic        r_fault;
    logic        r_ovf;
    logic        r_we;
    logic        r_c1;

    logic [2:0]  w_slot;
    logic [1:0]  w_slot_tag;
    logic [1:0]  w_wr_tag;
    logic [1:0]  w_wr_val;
    logic        w_patch;
    logic        w_fault;
    logic        w_ovf;
    logic        w_we;
    logic [2:0]  w_new_top;
    logic [15:0] w_word;

`ifdef FPU_TAG_CLASSIFY_EN
    logic [78:0] r_value;
    logic        w_unused_sign;

    // Sign bit plays no part in the tag class.
    assign w_unused_sign = op_value[79];

    function automatic logic [1:0] classify(input logic [78:0] v);
        logic [14:0] exp;
        logic [63:0] man;
        exp = v[78:64];
        man = v[63:0];
        if (exp == 15'd0 && man == 64'd0) begin
            classify = 2'b01;
        end else if (exp == 15'h7FFF || exp == 15'd0 || !man[63]) begin
            classify = 2'b10;
        end else begin
            classify = 2'b00;
        end
    endfunction

    assign w_wr_tag = classify(r_value);
`else
    assign w_wr_tag = r_tag;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: fixed three-step sequence per accepted op.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (op_valid) w_state_next = StCheck;
            StCheck:  w_state_next = StCommit;
            StCommit: w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    // Target slot per op: PUSH looks below TOP, POP at TOP, the rest at ST(i).
    always_comb begin
        w_slot = r_top + r_index;
        if (r_code == OpPush) begin
            w_slot = r_top - 3'd1;
        end else if (r_code == OpPop) begin
            w_slot = r_top;
        end
    end

    assign w_slot_tag = tag_in[{w_slot, 1'b0} +: 2];

    // Fault detection, new TOP and the tag value to drop into the target slot.
    always_comb begin
        w_fault   = 1'b0;
        w_ovf     = 1'b0;
        w_we      = 1'b0;
        w_patch   = 1'b0;
        w_wr_val  = w_wr_tag;
        w_new_top = r_top;
        unique case (r_code)
            OpPush: begin
                w_fault   = (w_slot_tag != TagEmpty);
                w_ovf     = 1'b1;
                w_we      = 1'b1;
                w_patch   = 1'b1;
                w_new_top = r_top - 3'd1;
            end
            OpPop: begin
                w_fault   = (w_slot_tag == TagEmpty);
                w_we      = 1'b1;
                w_patch   = 1'b1;
                w_wr_val  = TagEmpty;
                w_new_top = r_top + 3'd1;
            end
            OpWriteSt: begin
                w_we    = 1'b1;
                w_patch = 1'b1;
            end
            OpFree: begin
                w_we     = 1'b1;
                w_patch  = 1'b1;
                w_wr_val = TagEmpty;
            end
            OpInit: begin
                w_we      = 1'b1;
                w_new_top = INIT_TOP;
            end
            OpIncstp:  w_new_top = r_top + 3'd1;
            OpDecstp:  w_new_top = r_top - 3'd1;
            OpCheckSt: w_fault = (w_slot_tag == TagEmpty);
            default:   w_fault = 1'b0;
        endcase
    end

    // New tag word: untouched slots pass through from the sampled tag_in.
    always_comb begin
        w_word = tag_in;
        if (r_code == OpInit) begin
            w_word = 16'hFFFF;
        end else if (w_patch) begin
            w_word[{w_slot, 1'b0} +: 2] = w_wr_val;
        end
    end

    // Datapath registers: latch on accept, precompute in CHECK, retire in COMMIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_code      <= 3'd0;
            r_index     <= 3'd0;
            r_tag       <= 2'd0;
            r_top       <= INIT_TOP;
            r_new_top   <= INIT_TOP;
            r_tag_wdata <= 16'hFFFF;
            r_fault     <= 1'b0;
            r_ovf       <= 1'b0;
            r_we        <= 1'b0;
            r_c1        <= 1'b0;
`ifdef FPU_TAG_CLASSIFY_EN
            r_value     <= 79'd0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (op_valid) begin
                        r_code  <= op_code;
                        r_index <= op_index;
                        r_tag   <= op_tag;
`ifdef FPU_TAG_CLASSIFY_EN
                        r_value <= op_value[78:0];
`endif
                    end
                end
                StCheck: begin
                    r_fault   <= w_fault;
                    r_ovf     <= w_ovf;
                    r_we      <= w_we & ~w_fault;
                    r_new_top <= w_new_top;
                    if (!w_fault) begin
                        r_tag_wdata <= w_word;
                    end
                end
                StCommit: begin
                    if (!r_fault) begin
                        r_top <= r_new_top;
                    end
                    r_c1 <= r_fault & r_ovf;
                end
                default: r_fault <= 1'b0;
            endcase
        end
    end

    // Gating with reset makes a reset in COMMIT suppress that cycle's strobes.
    assign op_ready    = (r_state == StIdle);
    assign done        = (r_state == StCommit) & ~reset;
    assign tag_we      = done & r_we;
    assign stack_fault = done & r_fault;
    assign tag_wdata   = r_tag_wdata;
    assign top         = r_top;
    assign c1          = r_c1;

endmodule

// File: tb/tb_fpu_stack_tag_ctrl.sv
// Testbench for fpu_stack_tag_ctrl: table of directed ops against a modelled
// tag register, plus throughput, reset-abort and optional classify sequences.
module tb_fpu_stack_tag_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op_code;
    logic [2:0]  op_index;
    logic [1:0]  op_tag;
    logic [79:0] op_value;
    logic [15:0] tag_in;
    logic [15:0] tag_wdata;
    logic        tag_we;
    logic [2:0]  top;
    logic        done;
    logic        stack_fault;
    logic        c1;

    int passed = 0;
    int total  = 0;
    logic [15:0] tagreg;

    always #5 clk = ~clk;

    fpu_stack_tag_ctrl #(.INIT_TOP(3'd0)) dut (
        .clk         (clk),
        .reset       (reset),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_code     (op_code),
        .op_index    (op_index),
        .op_tag      (op_tag),
`ifdef FPU_TAG_CLASSIFY_EN
        .op_value    (op_value),
`endif
        .tag_in      (tag_in),
        .tag_wdata   (tag_wdata),
        .tag_we      (tag_we),
        .top         (top),
        .done        (done),
        .stack_fault (stack_fault),
        .c1          (c1)
    );

    typedef struct {
        logic [2:0]  code;
        logic [2:0]  idx;
        logic [1:0]  tag;
        logic        ld;
        logic [15:0] ld_val;
        logic        e_we;
        logic [15:0] e_wd;
        logic        e_fault;
        logic        e_c1;
        logic [2:0]  e_top;
    } vec_t;

    vec_t vecs [22];

    function automatic vec_t mk(input logic [2:0] code, input logic [2:0] idx,
                                input logic [1:0] tag, input logic ld,
                                input logic [15:0] ld_val, input logic e_we,
                                input logic [15:0] e_wd, input logic e_fault,
                                input logic e_c1, input logic [2:0] e_top);
        vec_t v;
        v.code = code;   v.idx = idx;       v.tag = tag;
        v.ld = ld;       v.ld_val = ld_val; v.e_we = e_we;
        v.e_wd = e_wd;   v.e_fault = e_fault;
        v.e_c1 = e_c1;   v.e_top = e_top;
        return v;
    endfunction

    // Extended-real operand whose class matches the given tag (00/01/10).
    function automatic logic [79:0] val_for_tag(input logic [1:0] t);
        logic [79:0] v;
        v = 80'd0;
        if (t == 2'b00) begin
            v[78:64] = 15'h3FFF;
            v[63]    = 1'b1;
        end else if (t == 2'b10) begin
            v[78:64] = 15'h7FFF;
            v[63]    = 1'b1;
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    logic        s_done, s_we, s_fault, s_c1, s_ready;
    logic [15:0] s_wd;
    logic [2:0]  s_top;

    // One op through accept/CHECK/COMMIT; samples COMMIT outputs and the T+3 state.
    task automatic do_op(input logic [2:0] code, input logic [2:0] idx,
                         input logic [1:0] tag, input logic [79:0] val);
        int n;
        @(negedge clk);
        op_code  = code;
        op_index = idx;
        op_tag   = tag;
        op_value = val;
        tag_in   = tagreg;
        op_valid = 1'b1;
        n = 0;
        while (!op_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) chk("ready_timeout", 32'(op_ready), 32'd1);
        @(posedge clk);
        #1 op_valid = 1'b0;
        @(posedge clk);
        #1;
        s_done  = done;
        s_we    = tag_we;
        s_wd    = tag_wdata;
        s_fault = stack_fault;
        @(posedge clk);
        #1;
        s_top   = top;
        s_c1    = c1;
        s_ready = op_ready;
        if (s_we) tagreg = s_wd;
        tag_in = tagreg;
    endtask

    localparam logic [2:0] PUSH = 3'd0, POP = 3'd1, WRST = 3'd2, FREE = 3'd3;
    localparam logic [2:0] INIT = 3'd4, INC = 3'd5, DEC = 3'd6, CHKST = 3'd7;

    int acc_cyc [4];
    int n_acc;

    initial begin
        // code idx tag ld ld_val we wdata fault c1 top
        vecs[0]  = mk(PUSH,  0, 2'b00, 1, 16'hFFFF, 1, 16'h3FFF, 0, 0, 7);
        vecs[1]  = mk(PUSH,  0, 2'b00, 0, 16'h0,    1, 16'h0FFF, 0, 0, 6);
        vecs[2]  = mk(PUSH,  0, 2'b00, 0, 16'h0,    1, 16'h03FF, 0, 0, 5);
        vecs[3]  = mk(PUSH,  0, 2'b00, 0, 16'h0,    1, 16'h00FF, 0, 0, 4);
        vecs[4]  = mk(PUSH,  0, 2'b00, 0, 16'h0,    1, 16'h003F, 0, 0, 3);
        vecs[5]  = mk(PUSH,  0, 2'b00, 0, 16'h0,    1, 16'h000F, 0, 0, 2);
        vecs[6]  = mk(PUSH,  0, 2'b00, 0, 16'h0,    1, 16'h0003, 0, 0, 1);
        vecs[7]  = mk(PUSH,  0, 2'b00, 0, 16'h0,    1, 16'h0000, 0, 0, 0);
        vecs[8]  = mk(PUSH,  0, 2'b00, 1, 16'h0000, 0, 16'h0,    1, 1, 0);
        vecs[9]  = mk(POP,   0, 2'b00, 1, 16'hFFFF, 0, 16'h0,    1, 0, 0);
        vecs[10] = mk(POP,   0, 2'b00, 1, 16'hFFFC, 1, 16'hFFFF, 0, 0, 1);
        vecs[11] = mk(DEC,   0, 2'b00, 0, 16'h0,    0, 16'h0,    0, 0, 0);
        vecs[12] = mk(DEC,   0, 2'b00, 0, 16'h0,    0, 16'h0,    0, 0, 7);
        vecs[13] = mk(DEC,   0, 2'b00, 0, 16'h0,    0, 16'h0,    0, 0, 6);
        vecs[14] = mk(FREE,  3, 2'b00, 1, 16'h0000, 1, 16'h000C, 0, 0, 6);
        vecs[15] = mk(WRST,  2, 2'b10, 0, 16'h0,    1, 16'h000E, 0, 0, 6);
        vecs[16] = mk(CHKST, 3, 2'b00, 0, 16'h0,    0, 16'h0,    1, 0, 6);
        vecs[17] = mk(CHKST, 2, 2'b00, 0, 16'h0,    0, 16'h0,    0, 0, 6);
        vecs[18] = mk(INC,   0, 2'b00, 0, 16'h0,    0, 16'h0,    0, 0, 7);
        vecs[19] = mk(INC,   0, 2'b00, 0, 16'h0,    0, 16'h0,    0, 0, 0);
        vecs[20] = mk(DEC,   0, 2'b00, 0, 16'h0,    0, 16'h0,    0, 0, 7);
        vecs[21] = mk(INIT,  0, 2'b00, 1, 16'h1234, 1, 16'hFFFF, 0, 0, 0);

        reset    = 1'b1;
        op_valid = 1'b0;
        op_code  = 3'd0;
        op_index = 3'd0;
        op_tag   = 2'd0;
        op_value = 80'd0;
        tagreg   = 16'hFFFF;
        tag_in   = tagreg;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", 32'(op_ready), 32'd1);
        chk("rst_top", 32'(top), 32'd0);
        chk("rst_we", 32'(tag_we), 32'd0);
        chk("rst_wdata", 32'(tag_wdata), 32'hFFFF);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fault", 32'(stack_fault), 32'd0);
        chk("rst_c1", 32'(c1), 32'd0);

        for (int i = 0; i < 22; i++) begin
            if (vecs[i].ld) tagreg = vecs[i].ld_val;
            do_op(vecs[i].code, vecs[i].idx, vecs[i].tag, val_for_tag(vecs[i].tag));
            chk($sformatf("v%0d_done", i), 32'(s_done), 32'd1);
            chk($sformatf("v%0d_we", i), 32'(s_we), 32'(vecs[i].e_we));
            if (vecs[i].e_we) chk($sformatf("v%0d_wdata", i), 32'(s_wd), 32'(vecs[i].e_wd));
            chk($sformatf("v%0d_fault", i), 32'(s_fault), 32'(vecs[i].e_fault));
            chk($sformatf("v%0d_c1", i), 32'(s_c1), 32'(vecs[i].e_c1));
            chk($sformatf("v%0d_top", i), 32'(s_top), 32'(vecs[i].e_top));
            chk($sformatf("v%0d_ready", i), 32'(s_ready), 32'd1);
        end

        // op_valid held high: accepts spaced exactly three cycles apart.
        @(negedge clk);
        op_code  = INC;
        op_valid = 1'b1;
        n_acc    = 0;
        for (int c = 0; c < 12; c++) begin
            if (op_ready && n_acc < 4) begin
                acc_cyc[n_acc] = c;
                n_acc++;
            end
            @(negedge clk);
        end
        op_valid = 1'b0;
        chk("thr_count", 32'(n_acc), 32'd4);
        for (int k = 1; k < 4; k++) begin
            if (k < n_acc) chk($sformatf("thr_gap%0d", k), 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd3);
        end
        repeat (3) @(posedge clk);
        #1 chk("thr_top", 32'(top), 32'd4);

        // Reset during CHECK aborts the op.
        @(negedge clk);
        op_code  = PUSH;
        op_tag   = 2'b00;
        op_value = val_for_tag(2'b00);
        tag_in   = tagreg;
        op_valid = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rchk_done", 32'(done), 32'd0);
        chk("rchk_we", 32'(tag_we), 32'd0);
        chk("rchk_top", 32'(top), 32'd0);
        reset = 1'b0;
        chk("rchk_ready", 32'(op_ready), 32'd1);
        @(posedge clk);
        #1 chk("rchk_done2", 32'(done), 32'd0);

        // Reset during COMMIT suppresses the strobes in that same cycle.
        do_op(INC, 0, 2'b00, 80'd0);
        chk("pre_top", 32'(s_top), 32'd1);
        @(negedge clk);
        op_code  = PUSH;
        tag_in   = 16'hFFFF;
        op_valid = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rcom_done", 32'(done), 32'd0);
        chk("rcom_we", 32'(tag_we), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        chk("rcom_top", 32'(top), 32'd0);
        chk("rcom_wdata", 32'(tag_wdata), 32'hFFFF);
        tagreg = 16'hFFFF;

`ifdef FPU_TAG_CLASSIFY_EN
        // op_tag disagrees with op_value: the classified value must win.
        begin
            logic [79:0] v;
            v = 80'd0;
            v[78:64] = 15'h7FFF;
            do_op(PUSH, 0, 2'b00, v);
            chk("cls_nan_wd", 32'(s_wd), 32'hBFFF);
            do_op(PUSH, 0, 2'b10, 80'd0);
            chk("cls_zero_wd", 32'(s_wd), 32'h9FFF);
            chk("cls_top", 32'(s_top), 32'd6);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, total);
        $fatal(1);
    end

endmodule

// File: doc/fpu_stack_tag_ctrl.md
# fpu_stack_tag_ctrl

Sequencer for the FPU tag register and stack-top pointer. Accepts one stack operation at a time from the FPU microsequencer, maps ST(i) to physical slots via TOP, and detects stack overflow/underflow against the current tag word. Produces a single-cycle tag-register write and TOP update per operation. Sits between the microsequencer and the FPU tag register; the tag register's output word feeds back into this block.

## Interface
- `INIT_TOP`, default 3'd0: TOP value loaded on reset and on INIT.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `op_valid` in 1: operation request.
- `op_ready` out 1: high only in IDLE; an op is accepted when `op_valid & op_ready`.
- `op_code` in 3: 000 PUSH, 001 POP, 010 WRITE_ST, 011 FREE, 100 INIT, 101 INCSTP, 110 DECSTP, 111 CHECK_ST.
- `op_index` in 3: i for ST(i) (WRITE_ST, FREE, CHECK_ST).
- `op_tag` in 2: tag to write (PUSH, WRITE_ST): 00 valid, 01 zero, 10 special, 11 empty.
- `tag_in` in 16: current tag word; physical slot p occupies bits [2p+1:2p].
- `tag_wdata` out 16: new tag word, registered.
- `tag_we` out 1: one-cycle write strobe to the tag register.
- `top` out 3: stack-top pointer.
- `done` out 1: one-cycle completion pulse.
- `stack_fault` out 1: pulses with `done` on overflow or underflow.
- `c1` out 1: registered; updated at every `done`: 1 on overflow, 0 otherwise.

## Operation
- FSM has three states: IDLE -> CHECK -> COMMIT -> IDLE. There are no other transitions. `reset` forces IDLE from any state.
- IDLE: `op_ready`=1. On accept, latch `op_code`, `op_index` and `op_tag`, then go to CHECK.
- CHECK: sample `tag_in`. Compute the physical slot, the fault flag, the new tag word and the new TOP into registers.
- COMMIT: assert `done`.
  - If there is no fault and the op writes tags: assert `tag_we`.
  - If there is no fault: load `top`.
  - On a fault: `tag_we`=0, `top` is unchanged, `stack_fault`=1.
- Physical slot for ST(i) = (TOP + i) mod 8. All pointer arithmetic is 3-bit wrap-around: 7+1 = 0, 0−1 = 7.
- Per-op behaviour:
  - PUSH: slot = TOP−1. If that slot's tag ≠ 11: overflow (fault, c1=1). Otherwise write the tag (`op_tag`) and set TOP = TOP−1.
  - POP: slot = TOP. If that slot's tag = 11: underflow (fault, c1=0). Otherwise write 11 and set TOP = TOP+1.
  - WRITE_ST: write the tag (`op_tag`) to slot (TOP+i). No fault.
  - FREE: write 11 to slot (TOP+i). No fault.
  - INIT: `tag_wdata`=16'hFFFF, `tag_we`=1, TOP = `INIT_TOP`. No fault.
  - INCSTP / DECSTP: TOP ± 1. `tag_we`=0. No fault.
  - CHECK_ST: if slot (TOP+i) is empty: underflow fault. Never writes tags or TOP.
- Tag bits for slots other than the target slot pass through unchanged from the sampled `tag_in`.
- Other writers to the tag register (e.g. environment load) must not write while the FSM is in CHECK or COMMIT.

## Timing
- Reset values:
  - FSM state: IDLE.
  - `op_ready`=1 (first cycle after the reset edge).
  - `top`=`INIT_TOP`.
  - `tag_we`=0.
  - `tag_wdata`=16'hFFFF.
  - `done`=0, `stack_fault`=0, `c1`=0.
- Accept at edge T. CHECK occupies cycle T+1. COMMIT occupies cycle T+2, with `tag_we`, `done` and `stack_fault` high.
- The new `top` and the tag register contents are visible from T+3. `op_ready` returns high at T+3.
- Throughput: one op per 3 cycles. `op_valid` is ignored while `op_ready`=0.
- Because `tag_in` is sampled in CHECK, the following op always sees the prior op's write.
- `reset` asserted in CHECK or COMMIT aborts the op: no `tag_we`, no `done`, and all outputs take their reset values.

## Configuration
- `FPU_TAG_CLASSIFY_EN` defined:
  - Adds input port `op_value` (80 bits, 8087 extended-real format).
  - PUSH and WRITE_ST ignore `op_tag` and classify `op_value`, using exponent = bits [78:64] and mantissa = bits [63:0]:
    - Exponent 0 and mantissa 0 -> 01.
    - Exponent 7FFF, or exponent 0 with nonzero mantissa, or nonzero exponent with bit 63 = 0 -> 10.
    - Otherwise -> 00.
  - Classification happens in CHECK; latency is unchanged.
- `FPU_TAG_CLASSIFY_EN` undefined: the `op_value` port is absent and `op_tag` is used directly.

## Test plan
- Reset then PUSH with `op_tag`=00 and `tag_in`=FFFF -> at T+2: `tag_we`=1, `tag_wdata`=3FFF (slot 7 = 00), `done`=1. At T+3: `top`=7.
- Eight PUSHes starting from TOP=0, then a ninth PUSH with `tag_in`=0000 -> ninth op: `stack_fault`=1, `c1`=1, `tag_we`=0, `top` stays 0.
- POP with TOP=0 and `tag_in`=FFFF -> underflow: `stack_fault`=1, `c1`=0, `top`=0. Then POP with `tag_in`=FFFC -> `tag_wdata`=FFFF, `top`=1.
- TOP=6, FREE with i=3 and `tag_in`=0000 -> slot 1 emptied: `tag_wdata`=000C. DECSTP from TOP=0 -> `top`=7, `tag_we`=0.
- `op_valid` held high continuously -> accepts are exactly 3 cycles apart. `reset` pulsed during CHECK -> no `done`, `top`=`INIT_TOP`, `op_ready`=1 on the next cycle.
- `FPU_TAG_CLASSIFY_EN` defined: PUSH with `op_value` exponent=7FFF -> pushed slot tag = 10. PUSH with `op_value`=0 -> pushed slot tag = 01.
